// File: rtl/sv_alu_seq.sv
// sv_alu_seq: registered WIDTH-bit, 8-op ALU with flags and valid/ready on both sides.
// Latency: 1 cycle for non-MUL ops; WIDTH+1 cycles for MUL (shift-add, one bit per cycle).
// Backpressure: result held in HOLD until popped; in_ready follows out_ready in HOLD, low during MUL.
// Optional macro SV_ALU_MUL_EN builds the iterative multiplier; without it op 111 flags err.
module sv_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             err
);
   localparam int SHAMT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
      OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
   } opcode_t;

`ifdef SV_ALU_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;
   localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0]   r_mplier;
   logic [SHAMT_W-1:0] r_cnt;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_is_mul;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dif;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_err;
   logic [WIDTH-1:0] r_res;
   logic             r_z;
   logic             r_n;
   logic             r_c;
   logic             r_err;

`ifdef SV_ALU_MUL_EN
   assign w_is_mul  = (opcode_t'(op) == OP_MUL);
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`else
   assign w_is_mul  = 1'b0;
`endif

   assign w_accept = in_valid && in_ready;
   assign w_sum    = {1'b0, a} + {1'b0, b};
   assign w_dif    = {1'b0, a} - {1'b0, b};
   assign res      = r_res;
   assign flag_z   = r_z;
   assign flag_n   = r_n;
   assign flag_c   = r_c;
   assign err      = r_err;

   // State register; reset aborts any multiply or held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state plus handshake outputs; a pop and a new accept may share one edge.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = w_is_mul ? state_t'(2'd1) : HOLD;
         end
`ifdef SV_ALU_MUL_EN
         MUL: begin
            if (r_cnt == LAST) w_state_nxt = HOLD;
         end
`endif
         HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) w_state_nxt = w_is_mul ? state_t'(2'd1) : HOLD;
               else          w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Single-cycle result for every op except the iterative multiply.
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_err = 1'b0;
      case (opcode_t'(op))
         OP_ADD: begin w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
         OP_SUB: begin w_res = w_dif[WIDTH-1:0]; w_c = w_dif[WIDTH]; end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_SHL: w_res = a << b[SHAMT_W-1:0];
         OP_SHR: w_res = a >> b[SHAMT_W-1:0];
`ifdef SV_ALU_MUL_EN
         default: w_res = '0;
`else
         default: w_err = 1'b1;
`endif
      endcase
   end

   // Result/flag registers and the shift-add multiplier datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res <= '0;
         r_z   <= 1'b0;
         r_n   <= 1'b0;
         r_c   <= 1'b0;
         r_err <= 1'b0;
`ifdef SV_ALU_MUL_EN
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
`endif
      end else begin
         if (w_accept && !w_is_mul) begin
            r_res <= w_res;
            r_z   <= (w_res == '0);
            r_n   <= w_res[WIDTH-1];
            r_c   <= w_c;
            r_err <= w_err;
         end
`ifdef SV_ALU_MUL_EN
         if (w_accept && w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
         end else if (r_state == MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
               r_res <= w_acc_nxt[WIDTH-1:0];
               r_z   <= (w_acc_nxt[WIDTH-1:0] == '0);
               r_n   <= w_acc_nxt[WIDTH-1];
               r_c   <= |w_acc_nxt[2*WIDTH-1:WIDTH];
               r_err <= 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_sv_alu_seq.sv
// Testbench for sv_alu_seq (WIDTH=8): directed spec cases plus random ops against an arithmetic model.
// Honours SV_ALU_MUL_EN the same way the design does.
module tb_sv_alu_seq;
   localparam int W = 8;
`ifdef SV_ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] res;
   logic         flag_z;
   logic         flag_n;
   logic         flag_c;
   logic         err;

   int checks = 0;
   int errors = 0;

   sv_alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, truncated to W bits.
   function automatic void model(input int o, input int x, input int y,
                                 output int r, output int c, output int e, output int lat);
      int full;
      full = 0; c = 0; e = 0; lat = 1;
      case (o)
         0: begin full = x + y; c = (full > 255) ? 1 : 0; end
         1: begin full = x - y; c = (x < y) ? 1 : 0; end
         2: full = x & y;
         3: full = x | y;
         4: full = x ^ y;
         5: full = x << (y % W);
         6: full = x >> (y % W);
         default: begin
            if (MUL_EN) begin
               full = x * y; c = (full > 255) ? 1 : 0; lat = W + 1;
            end else begin
               full = 0; e = 1;
            end
         end
      endcase
      r = full & 255;
   endfunction

   // Issue one beat (popping any held result on the same edge), wait for it, optionally stall, check.
   task automatic do_op(input int o, input int x, input int y, input int hold);
      int er, ec, ee, el, n;
      model(o, x, y, er, ec, ee, el);
      op = 3'(o); a = 8'(x); b = 8'(y);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, el);
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_res", {24'd0, res}, er);
         end
      end
      check("res", {24'd0, res}, er);
      check("flag_z", {31'd0, flag_z}, (er == 0) ? 1 : 0);
      check("flag_n", {31'd0, flag_n}, (er >= 128) ? 1 : 0);
      check("flag_c", {31'd0, flag_c}, ec);
      check("err", {31'd0, err}, ee);
   endtask

   initial begin
      bit saw;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 1);
      check("rst_res", {24'd0, res}, 0);
      check("rst_flags", {28'd0, flag_z, flag_n, flag_c, err}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      do_op(0, 'hF0, 'h20, 0);
      check("add_lit_res", {24'd0, res}, 'h10);
      check("add_lit_c", {31'd0, flag_c}, 1);
      do_op(1, 'h05, 'h05, 0);
      check("sub_eq_z", {31'd0, flag_z}, 1);
      do_op(1, 'h03, 'h05, 1);
      check("sub_lit_res", {24'd0, res}, 'hFE);
      do_op(5, 'h81, 'h09, 0);
      check("shl_lit_res", {24'd0, res}, 'h02);
      do_op(6, 'h80, 'h07, 0);
      check("shr_lit_res", {24'd0, res}, 'h01);
      do_op(7, 'h10, 'h11, 0);
      check("mul_lit_res", {24'd0, res}, MUL_EN ? 'h10 : 0);
      do_op(7, 'h0C, 'h0A, 0);
      check("mul2_lit_res", {24'd0, res}, MUL_EN ? 'h78 : 0);

      // Back-pressure: XOR held 5 cycles while an AND beat waits, then back-to-back
      op = 3'd4; a = 8'hAA; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      op = 3'd2; a = 8'h3C; b = 8'h0F;
      check("bp_valid", {31'd0, out_valid}, 1);
      check("bp_res", {24'd0, res}, 'h55);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_hold_res", {24'd0, res}, 'h55);
         check("bp_in_ready", {31'd0, in_ready}, 0);
         check("bp_hold_valid", {31'd0, out_valid}, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b_valid", {31'd0, out_valid}, 1);
      check("b2b_res", {24'd0, res}, 'h0C);
      @(posedge clk); #1;
      check("b2b_drained", {31'd0, out_valid}, 0);

      // Random ops with random sink stalls
      for (int i = 0; i < 40; i++)
         do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("rand_drained", {31'd0, out_valid}, 0);

      // Reset in the middle of an operation: nothing may emerge afterwards
      op = MUL_EN ? 3'd7 : 3'd0; a = 8'h10; b = 8'h11;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, out_valid}, 0);
      check("midrst_in_ready", {31'd0, in_ready}, 1);
      check("midrst_res", {24'd0, res}, 0);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      check("no_stale_result", {31'd0, saw}, 0);
      do_op(0, 'h7F, 'h01, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
